// File: rtl/pwm_multi_channel_if.sv
// Register/strobe bundle between the host and the multi-channel PWM block.
// master = host side (drives requests), slave = PWM block.
interface pwm_multi_channel_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 28
);
  logic [CW-1:0]     cycle_in;
  logic [NCH*CW-1:0] duty_in;
  logic              center_in;
  logic              load;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    pwm_out;
  logic              period_start;
  logic              pending;

  modport master (
    output cycle_in, duty_in, center_in, load, ch_en,
    input  pwm_out, period_start, pending
  );

  modport slave (
    input  cycle_in, duty_in, center_in, load, ch_en,
    output pwm_out, period_start, pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with shadowed period/duty/mode applied only at period boundaries,
// edge- or centre-aligned counting, per-channel enable and a period-start strobe.
module pwm_multi_channel #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 28
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  pwm_multi_channel_if.slave  bus
);

  localparam logic [CW-1:0] One = CW'(1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dir_q, dir_d;             // 0 = up, 1 = down
  logic [CW-1:0]     act_cycle_q, act_cycle_d;
  logic [NCH*CW-1:0] act_duty_q, act_duty_d;
  logic              act_center_q, act_center_d;
  logic [CW-1:0]     sh_cycle_q, sh_cycle_d;
  logic [NCH*CW-1:0] sh_duty_q, sh_duty_d;
  logic              sh_center_q, sh_center_d;
  logic              pending_q, pending_d;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              boundary;

  // A stopped generator (C==0) treats every cycle as a boundary so a new load lands at once.
  always_comb begin
    if (act_cycle_q == '0) begin
      boundary = 1'b1;
    end else if (act_center_q) begin
      boundary = dir_q && (cnt_q == '0);
    end else begin
      boundary = (cnt_q == act_cycle_q - One);
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    act_cycle_d    = act_cycle_q;
    act_duty_d     = act_duty_q;
    act_center_d   = act_center_q;
    sh_cycle_d     = sh_cycle_q;
    sh_duty_d      = sh_duty_q;
    sh_center_d    = sh_center_q;
    pending_d      = pending_q;
    period_start_d = 1'b0;

    if (boundary) begin
      cnt_d     = '0;
      dir_d     = 1'b0;
      pending_d = 1'b0;
      // A load coinciding with the boundary bypasses the shadow entirely.
      if (bus.load) begin
        act_cycle_d  = bus.cycle_in;
        act_duty_d   = bus.duty_in;
        act_center_d = bus.center_in;
      end else if (pending_q) begin
        act_cycle_d  = sh_cycle_q;
        act_duty_d   = sh_duty_q;
        act_center_d = sh_center_q;
      end
      period_start_d = (act_cycle_d != '0);
    end else begin
      if (act_center_q) begin
        if (!dir_q) begin
          // Top value is held for two clocks: turn around without stepping.
          if (cnt_q == act_cycle_q - One) begin
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + One;
          end
        end else begin
          cnt_d = cnt_q - One;
        end
      end else begin
        cnt_d = cnt_q + One;
      end
      if (bus.load) begin
        sh_cycle_d  = bus.cycle_in;
        sh_duty_d   = bus.duty_in;
        sh_center_d = bus.center_in;
        pending_d   = 1'b1;
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = bus.ch_en[i] && (act_cycle_q != '0) && (cnt_q < act_duty_q[i*CW +: CW]);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt_q          <= '0;
      dir_q          <= 1'b0;
      act_cycle_q    <= '0;
      act_duty_q     <= '0;
      act_center_q   <= 1'b0;
      sh_cycle_q     <= '0;
      sh_duty_q      <= '0;
      sh_center_q    <= 1'b0;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      act_cycle_q    <= act_cycle_d;
      act_duty_q     <= act_duty_d;
      act_center_q   <= act_center_d;
      sh_cycle_q     <= sh_cycle_d;
      sh_duty_q      <= sh_duty_d;
      sh_center_q    <= sh_center_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a phase-based reference model pushes the expected
// outputs for each clock, which are popped and compared one clock later.
module tb_pwm_multi_channel;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 28;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.NCH(NCH), .CW(CW)) bus ();

  pwm_multi_channel #(.NCH(NCH), .CW(CW)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  typedef struct {
    logic [NCH-1:0] pwm;
    logic           ps;
    logic           pend;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: position within the period, cnt derived from it.
  longint unsigned m_c, m_phase, sh_c;
  longint unsigned m_d [NCH];
  longint unsigned sh_d [NCH];
  logic m_center, sh_center, m_pend;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned model_cnt();
    if (m_center && m_phase >= m_c) return 2 * m_c - 1 - m_phase;
    return m_phase;
  endfunction

  task automatic step();
    exp_t e;
    longint unsigned per, cnt;
    logic bnd;
    per = (m_c == 0) ? 1 : (m_center ? 2 * m_c : m_c);
    cnt = model_cnt();
    bnd = (m_phase == per - 1);
    for (int i = 0; i < NCH; i++) e.pwm[i] = bus.ch_en[i] && (m_c != 0) && (cnt < m_d[i]);
    e.ps = 1'b0;
    if (rst) begin
      m_c = 0; m_center = 0; m_phase = 0; sh_c = 0; sh_center = 0; m_pend = 0;
      for (int i = 0; i < NCH; i++) begin m_d[i] = 0; sh_d[i] = 0; end
      e.pwm = '0;
    end else if (bnd) begin
      if (bus.load) begin
        m_c = bus.cycle_in; m_center = bus.center_in;
        for (int i = 0; i < NCH; i++) m_d[i] = bus.duty_in[i*CW +: CW];
      end else if (m_pend) begin
        m_c = sh_c; m_center = sh_center;
        for (int i = 0; i < NCH; i++) m_d[i] = sh_d[i];
      end
      m_pend  = 0;
      m_phase = 0;
      e.ps    = (m_c != 0);
    end else begin
      m_phase++;
      if (bus.load) begin
        sh_c = bus.cycle_in; sh_center = bus.center_in; m_pend = 1;
        for (int i = 0; i < NCH; i++) sh_d[i] = bus.duty_in[i*CW +: CW];
      end
    end
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("pwm_out", 64'(bus.pwm_out), 64'(e.pwm));
    check_eq("period_start", 64'(bus.period_start), 64'(e.ps));
    check_eq("pending", 64'(bus.pending), 64'(e.pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int c, input int d0, input int d1, input int d2, input int d3,
                         input logic ctr);
    bus.cycle_in  = CW'(c);
    bus.duty_in   = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
    bus.center_in = ctr;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input longint unsigned target);
    int guard;
    guard = 0;
    while (model_cnt() != target && guard < 200) begin
      step();
      guard++;
    end
    check_eq(tag, 64'(model_cnt() == target), 64'd1);
  endtask

  // Length of one period between period_start pulses, plus ch0 high count and pattern.
  task automatic measure_period(input string tag, output int n, output int ones,
                                output logic [15:0] pat);
    int guard;
    guard = 0; n = 0; ones = 0; pat = '0;
    while (bus.period_start !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    check_eq(tag, 64'(bus.period_start), 64'd1);
    do begin
      step();
      n++;
      ones += int'(bus.pwm_out[0]);
      pat = {pat[14:0], bus.pwm_out[0]};
    end while (bus.period_start !== 1'b1 && n < 100);
  endtask

  int n, ones;
  logic [15:0] pat;

  initial begin
    bus.cycle_in = '0; bus.duty_in = '0; bus.center_in = 1'b0; bus.load = 1'b0;
    bus.ch_en = '1;
    m_c = 0; m_center = 0; m_phase = 0; sh_c = 0; sh_center = 0; m_pend = 0;
    for (int i = 0; i < NCH; i++) begin m_d[i] = 0; sh_d[i] = 0; end

    rst = 1'b1;
    run(3);
    rst = 1'b0;
    check_eq("rst_pwm", 64'(bus.pwm_out), 64'd0);
    check_eq("rst_pend", 64'(bus.pending), 64'd0);
    run(3);

    // 1: edge mode C=10 D0=3
    do_load(10, 3, 0, 0, 0, 1'b0);
    check_eq("t1_ps_first", 64'(bus.period_start), 64'd1);
    measure_period("t1_ps_seen", n, ones, pat);
    check_eq("t1_period", 64'(n), 64'd10);
    check_eq("t1_high", 64'(ones), 64'd3);

    // 2: duty change mid-period waits for the boundary
    wait_cnt("t2_wait", 4);
    do_load(10, 7, 0, 0, 0, 1'b0);
    check_eq("t2_pending", 64'(bus.pending), 64'd1);
    measure_period("t2_ps_seen", n, ones, pat);
    check_eq("t2_period", 64'(n), 64'd10);
    check_eq("t2_high", 64'(ones), 64'd7);

    // 3: duty extremes, plus channel enable toggling mid-period
    do_load(10, 0, 10, 15, 5, 1'b0);
    run(14);
    bus.ch_en = 4'b1001;
    run(5);
    check_eq("t3_en_off", 64'(bus.pwm_out[2:1]), 64'd0);
    bus.ch_en = 4'b1111;
    run(13);

    // 4: centre mode C=4 D0=2
    do_load(4, 2, 0, 0, 0, 1'b1);
    measure_period("t4_ps_seen", n, ones, pat);
    check_eq("t4_period", 64'(n), 64'd8);
    check_eq("t4_pattern", 64'(pat[7:0]), 64'b11000011);
    run(10);

    // 5: stop then restart
    do_load(0, 0, 0, 0, 0, 1'b0);
    run(12);
    check_eq("t5_stopped", 64'(bus.pwm_out), 64'd0);
    do_load(5, 2, 0, 0, 0, 1'b0);
    check_eq("t5_restart_ps", 64'(bus.period_start), 64'd1);
    run(12);

    // 6: reset while a shadow update is pending
    do_load(10, 3, 0, 0, 0, 1'b0);
    wait_cnt("t6_wait_a", 8);
    wait_cnt("t6_wait_b", 2);
    do_load(10, 6, 0, 0, 0, 1'b0);
    wait_cnt("t6_wait_c", 6);
    check_eq("t6_pend_before", 64'(bus.pending), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_rst_pwm", 64'(bus.pwm_out), 64'd0);
    check_eq("t6_rst_pend", 64'(bus.pending), 64'd0);
    run(12);
    check_eq("t6_idle", 64'(bus.pwm_out), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
